shot_round_controller: RTL and testbench

- Game-level sequencer that owns the shared 60 Hz physics tick.
- Debounces the shot button and gates it into the ball kinematics datapath.
- Resets the kinematics between shots and judges each shot as a make or a miss from ball screen coordinates.
- Counts shots and makes per game and declares game over; sits between the board button, the kinematics block and the score/HUD display.

---
 rtl/shot_round_controller.sv | 273 +++++++++++++++++++++++++++
 tb/tb_shot_round_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : shot_round_controller
// Purpose  : Game-level sequencer for the shot game. Generates the shared
//            physics tick, debounces the shot button, gates it into the
//            kinematics block, resets the kinematics between shots, judges
//            each shot as a make or a miss from ball screen coordinates and
//            keeps the per-game shot/make tallies.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   btn_raw      in   asynchronous shot button
//   ball_x       in   [9:0] ball centre screen x from kinematics
//   ball_y       in   [9:0] ball centre screen y from kinematics (grows down)
//   phys_tick    out  one-clk pulse every TICK_DIV cycles
//   btn_gated    out  debounced button level forwarded to kinematics (AIM only)
//   kin_rst      out  kinematics reset request, level
//   state        out  [2:0] IDLE=0 AIM=1 FLIGHT=2 RESULT=3 GAME_OVER=4
//   shots_taken  out  [4:0] shots launched this game
//   makes        out  [4:0] shots scored this game
//   make_pulse   out  one-clk pulse on make detection
//   miss_pulse   out  one-clk pulse on miss detection
//   game_over    out  high while in GAME_OVER
// ============================================================================
module shot_round_controller #(
  parameter int TICK_DIV           = 1666667,
  parameter int DEBOUNCE_TICKS     = 3,
  parameter int SHOTS_PER_GAME     = 10,
  parameter int SHOT_TIMEOUT_TICKS = 300,
  parameter int RESULT_HOLD_TICKS  = 90,
  parameter int HOOP_X_L           = 610,
  parameter int HOOP_X_R           = 630,
  parameter int HOOP_Y             = 256,
  parameter int BALL_R             = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       phys_tick,
  output logic       btn_gated,
  output logic       kin_rst,
  output logic [2:0] state,
  output logic [4:0] shots_taken,
  output logic [4:0] makes,
  output logic       make_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  // --------------------------------------------------------------------------
  // Derived widths and terminal counts
  // --------------------------------------------------------------------------
  localparam int TICK_W = (TICK_DIV > 1)           ? $clog2(TICK_DIV)           : 1;
  localparam int DB_W   = (DEBOUNCE_TICKS > 1)     ? $clog2(DEBOUNCE_TICKS)     : 1;
  localparam int FT_W   = (SHOT_TIMEOUT_TICKS > 1) ? $clog2(SHOT_TIMEOUT_TICKS) : 1;
  localparam int HT_W   = (RESULT_HOLD_TICKS > 1)  ? $clog2(RESULT_HOLD_TICKS)  : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [FT_W-1:0]   FT_LAST    = FT_W'(SHOT_TIMEOUT_TICKS - 1);
  localparam logic [HT_W-1:0]   HT_LAST    = HT_W'(RESULT_HOLD_TICKS - 1);
  localparam logic [4:0]        SHOTS_LAST = 5'(SHOTS_PER_GAME);

  // The ball counts as in the hoop only if its whole body clears both rims.
  localparam logic [9:0] X_MIN = 10'(HOOP_X_L + BALL_R);
  localparam logic [9:0] X_MAX = 10'(HOOP_X_R - BALL_R);
  localparam logic [9:0] Y_RIM = 10'(HOOP_Y);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_AIM       = 3'd1,
    S_FLIGHT    = 3'd2,
    S_RESULT    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [TICK_W-1:0] tick_cnt;
  logic              sync_meta;
  logic              sync_out;
  logic              btn_db;
  logic [DB_W-1:0]   db_streak;
  logic [FT_W-1:0]   flight_timer;
  logic [HT_W-1:0]   hold_timer;
  logic [9:0]        prev_y;

  logic              db_flip;
  logic              db_rise;
  logic              db_fall;
  logic              cross_make;
  logic              launch;
  logic              hit;
  logic              miss;
  logic              new_game;

  // --------------------------------------------------------------------------
  // Physics tick: free-running divider, pulse decoded from the terminal count
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign phys_tick = (tick_cnt == TICK_LAST);

  // --------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, then a tick-sampled streak debouncer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
    end
  end

  // The FSM reacts to the debounced edge on the same tick the level flips,
  // so the edges are decoded from the flip condition, not from a delayed copy.
  assign db_flip = phys_tick && (sync_out != btn_db) && (db_streak == DB_LAST);
  assign db_rise = db_flip && !btn_db;
  assign db_fall = db_flip &&  btn_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db    <= 1'b0;
      db_streak <= '0;
    end else if (phys_tick) begin
      if (sync_out != btn_db) begin
        if (db_streak == DB_LAST) begin
          btn_db    <= sync_out;
          db_streak <= '0;
        end else begin
          db_streak <= db_streak + DB_W'(1);
        end
      end else begin
        // Any agreeing sample breaks the streak.
        db_streak <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Make judgement: downward crossing of the rim line inside the hoop window
  // --------------------------------------------------------------------------
  assign cross_make = (prev_y < Y_RIM) && (ball_y >= Y_RIM) &&
                      (ball_x >= X_MIN) && (ball_x <= X_MAX);

  // --------------------------------------------------------------------------
  // Round FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kin_rst   = 1'b1;
    btn_gated = 1'b0;
    game_over = 1'b0;
    launch    = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    new_game  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (db_rise) begin
          state_d = S_AIM;
        end
      end
      S_AIM: begin
        kin_rst   = 1'b0;
        btn_gated = btn_db;
        if (db_fall) begin
          state_d = S_FLIGHT;
          launch  = 1'b1;
        end
      end
      S_FLIGHT: begin
        kin_rst = 1'b0;
        if (phys_tick) begin
          // A make on the timeout tick still counts as a make.
          if (cross_make) begin
            hit     = 1'b1;
            state_d = S_RESULT;
          end else if (flight_timer == FT_LAST) begin
            miss    = 1'b1;
            state_d = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (phys_tick && (hold_timer == HT_LAST)) begin
          state_d = (shots_taken == SHOTS_LAST) ? S_GAME_OVER : S_IDLE;
        end
      end
      S_GAME_OVER: begin
        game_over = 1'b1;
        // The press that starts a new game is consumed here; IDLE needs
        // a fresh rising edge before a shot can begin.
        if (db_rise) begin
          new_game = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state = state_q;

  // --------------------------------------------------------------------------
  // Shot datapath: tallies, flight/hold timers, previous-y sample, pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shots_taken  <= '0;
      makes        <= '0;
      flight_timer <= '0;
      hold_timer   <= '0;
      prev_y       <= '0;
      make_pulse   <= 1'b0;
      miss_pulse   <= 1'b0;
    end else begin
      make_pulse <= hit;
      miss_pulse <= miss;

      if (launch) begin
        shots_taken  <= shots_taken + 5'd1;
        flight_timer <= '0;
        prev_y       <= ball_y;
      end else if ((state_q == S_FLIGHT) && phys_tick) begin
        flight_timer <= flight_timer + FT_W'(1);
        prev_y       <= ball_y;
      end

      if (hit || miss) begin
        hold_timer <= '0;
      end else if ((state_q == S_RESULT) && phys_tick) begin
        hold_timer <= hold_timer + HT_W'(1);
      end

      if (hit) begin
        makes <= makes + 5'd1;
      end

      if (new_game) begin
        shots_taken <= '0;
        makes       <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shot_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_round_controller
// Purpose  : Scoreboard bench for shot_round_controller. Stimulus pushes the
//            expected observable event (state change and/or result pulse)
//            into a queue; a monitor pops and compares whenever the DUT
//            changes state or raises a pulse. A second monitor tracks the
//            physics tick against a cycle count.
// Revision : 1.0  initial release
// ============================================================================
module tb_shot_round_controller;

  localparam int TD   = 4;
  localparam int DB   = 2;
  localparam int SPG  = 2;
  localparam int TO   = 10;
  localparam int HOLD = 3;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       btn_raw = 1'b0;
  logic [9:0] ball_x  = 10'd620;
  logic [9:0] ball_y  = 10'd250;

  logic       phys_tick;
  logic       btn_gated;
  logic       kin_rst;
  logic [2:0] state;
  logic [4:0] shots_taken;
  logic [4:0] makes;
  logic       make_pulse;
  logic       miss_pulse;
  logic       game_over;

  shot_round_controller #(
    .TICK_DIV          (TD),
    .DEBOUNCE_TICKS    (DB),
    .SHOTS_PER_GAME    (SPG),
    .SHOT_TIMEOUT_TICKS(TO),
    .RESULT_HOLD_TICKS (HOLD),
    .HOOP_X_L          (610),
    .HOOP_X_R          (630),
    .HOOP_Y            (256),
    .BALL_R            (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .phys_tick  (phys_tick),
    .btn_gated  (btn_gated),
    .kin_rst    (kin_rst),
    .state      (state),
    .shots_taken(shots_taken),
    .makes      (makes),
    .make_pulse (make_pulse),
    .miss_pulse (miss_pulse),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] shots;
    logic [4:0] mkc;
    logic       mk;
    logic       ms;
    logic       go;
    logic       kr;
    logic       bg;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t ev(input int st, input int shots, input int mkc,
                             input int mk, input int ms, input int go,
                             input int kr, input int bg);
    ev_t e;
    e.st    = st[2:0];
    e.shots = shots[4:0];
    e.mkc   = mkc[4:0];
    e.mk    = mk[0];
    e.ms    = ms[0];
    e.go    = go[0];
    e.kr    = kr[0];
    e.bg    = bg[0];
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("st=%0d shots=%0d makes=%0d mk=%0d ms=%0d go=%0d kr=%0d bg=%0d",
                     e.st, e.shots, e.mkc, e.mk, e.ms, e.go, e.kr, e.bg);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // --------------------------------------------------------------------------
  // Event monitor / scoreboard
  // --------------------------------------------------------------------------
  logic       mon_en  = 1'b0;
  logic [2:0] last_st = 3'd0;
  int         ev_idx  = 0;
  ev_t        got_ev;
  ev_t        want_ev;

  always @(negedge clk) begin
    if (mon_en) begin
      if (state !== last_st || make_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
        got_ev.st    = state;
        got_ev.shots = shots_taken;
        got_ev.mkc   = makes;
        got_ev.mk    = make_pulse;
        got_ev.ms    = miss_pulse;
        got_ev.go    = game_over;
        got_ev.kr    = kin_rst;
        got_ev.bg    = btn_gated;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event%0d unexpected: got %s required no event", ev_idx, fmt(got_ev));
        end else begin
          want_ev = exp_q.pop_front();
          if (got_ev !== want_ev) begin
            errors++;
            $display("FAIL event%0d: got %s required %s", ev_idx, fmt(got_ev), fmt(want_ev));
          end
        end
        ev_idx++;
      end
      last_st = state;
    end
  end

  // --------------------------------------------------------------------------
  // Physics tick monitor: pulse on every TD-th cycle after reset release
  // --------------------------------------------------------------------------
  int   cyc    = 0;
  logic tick_en = 1'b0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (tick_en) begin
      checks++;
      if (phys_tick !== ((cyc % TD) == TD - 1)) begin
        errors++;
        $display("FAIL phys_tick at cycle %0d: got %0d required %0d",
                 cyc, phys_tick, ((cyc % TD) == TD - 1));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Advance to the falling edge inside the n-th following tick cycle; inputs
  // changed there are seen by the upcoming tick edge.
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      @(negedge clk);
      while (phys_tick !== 1'b1 && guard < 4 * TD) begin
        @(negedge clk);
        guard++;
      end
      if (phys_tick !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL tick_wait: got phys_tick=0 required 1");
        return;
      end
    end
  endtask

  // Press, hold and release from IDLE. Returns at the falling edge just
  // before the tick that enters FLIGHT, so tick_wait(k) afterwards lands on
  // the k-th FLIGHT tick.
  task automatic launch(input int shots_after, input int makes_now);
    exp_q.push_back(ev(1, shots_after - 1, makes_now, 0, 0, 0, 0, 1));
    btn_raw = 1'b1;
    tick_wait(3);
    btn_raw = 1'b0;
    exp_q.push_back(ev(2, shots_after, makes_now, 0, 0, 0, 0, 0));
    tick_wait(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    tick_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",      state,       0);
    chk("rst_kin_rst",    kin_rst,     1);
    chk("rst_shots",      shots_taken, 0);
    chk("rst_makes",      makes,       0);
    chk("rst_btn_gated",  btn_gated,   0);
    chk("rst_game_over",  game_over,   0);
    chk("rst_make_pulse", make_pulse,  0);
    chk("rst_miss_pulse", miss_pulse,  0);
    chk("rst_phys_tick",  phys_tick,   0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick_wait(1);

    // One-tick glitch: shorter than the debounce streak, no state change.
    btn_raw = 1'b1;
    tick_wait(1);
    btn_raw = 1'b0;
    tick_wait(4);
    chk("glitch_state",   state,   0);
    chk("glitch_kin_rst", kin_rst, 1);

    // Shot 1: clean make through the middle of the hoop.
    ball_x = 10'd620;
    ball_y = 10'd250;
    launch(1, 0);
    exp_q.push_back(ev(3, 1, 1, 1, 0, 0, 1, 0));
    tick_wait(1);
    ball_y = 10'd258;
    tick_wait(1);
    ball_y = 10'd250;
    exp_q.push_back(ev(0, 1, 1, 0, 0, 0, 1, 0));
    tick_wait(3);

    // Shot 2: crosses the rim left of the window, then times out -> miss,
    // and being the last shot it ends the game.
    ball_x = 10'd612;
    launch(2, 1);
    tick_wait(1);
    ball_y = 10'd258;
    exp_q.push_back(ev(3, 2, 1, 0, 1, 0, 1, 0));
    tick_wait(9);
    exp_q.push_back(ev(4, 2, 1, 0, 0, 1, 1, 0));
    tick_wait(4);
    ball_y = 10'd250;

    // Press in GAME_OVER clears the tallies; holding it must not start a shot.
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0));
    btn_raw = 1'b1;
    tick_wait(3);
    tick_wait(4);
    chk("no_auto_aim", state, 0);
    btn_raw = 1'b0;
    tick_wait(4);
    chk("new_game_state", state,       0);
    chk("new_game_shots", shots_taken, 0);
    chk("new_game_makes", makes,       0);

    // Shot 3: rim crossing at the right window edge on the timeout tick.
    ball_x = 10'd626;
    ball_y = 10'd250;
    launch(1, 0);
    exp_q.push_back(ev(3, 1, 1, 1, 0, 0, 1, 0));
    tick_wait(10);
    ball_y = 10'd258;
    exp_q.push_back(ev(0, 1, 1, 0, 0, 0, 1, 0));
    tick_wait(1);
    ball_y = 10'd250;
    tick_wait(3);

    // Shot 4: reset during flight returns everything to reset values.
    ball_x = 10'd620;
    launch(2, 1);
    tick_wait(5);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state",   state,       0);
    chk("midrst_kin_rst", kin_rst,     1);
    chk("midrst_shots",   shots_taken, 0);
    chk("midrst_makes",   makes,       0);
    @(negedge clk);
    rst = 1'b0;
    tick_wait(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
